// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, one-outstanding imem handshake, 2-entry {instr,pc} buffer to decode.
// Redirect flushes the buffer and kills the in-flight response; decode sees the new stream after refetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        misalign_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] req_pc_q;
  logic        kill_q;
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_pc_q    [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q;
  logic        misalign_q;

  logic        push, pop;
  logic [1:0]  count_d;
  logic        rd_ptr_d, wr_ptr_d;

  // Request is withheld in the redirect cycle so no stale-target grant can occur.
  assign imem_req  = rst && (state_q == IDLE) && (count_q != 2'd2) && !redirect;
  assign imem_addr = fetch_pc_q;

  assign instr_valid  = (count_q != 2'd0);
  assign instr        = instr_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign pc           = instr_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;
  assign pc_plus4     = instr_valid ? fifo_pc_q[rd_ptr_q] + 32'd4 : 32'h0;
  assign misalign_err = misalign_q;

  assign push = (state_q == WAIT) && imem_rvalid && !kill_q;
  assign pop  = instr_valid && instr_ready;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      fetch_pc_q      <= RESET_PC;
      req_pc_q        <= 32'h0;
      kill_q          <= 1'b0;
      fifo_instr_q[0] <= 32'h0;
      fifo_instr_q[1] <= 32'h0;
      fifo_pc_q[0]    <= 32'h0;
      fifo_pc_q[1]    <= 32'h0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      misalign_q      <= 1'b0;
    end else begin
      misalign_q <= redirect && (redirect_pc[1:0] != 2'b00);
      if (redirect) begin
        count_q    <= 2'd0;
        rd_ptr_q   <= 1'b0;
        wr_ptr_q   <= 1'b0;
        fetch_pc_q <= {redirect_pc[31:2], 2'b00};
        // An outstanding response still has to be absorbed before the next request.
        if (state_q == WAIT) begin
          if (imem_rvalid) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
          end else begin
            kill_q  <= 1'b1;
          end
        end
      end else begin
        if (push) begin
          fifo_instr_q[wr_ptr_q] <= imem_rdata;
          fifo_pc_q[wr_ptr_q]    <= req_pc_q;
        end
        count_q  <= count_d;
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        case (state_q)
          IDLE: begin
            if (imem_req && imem_gnt) begin
              req_pc_q   <= fetch_pc_q;
              fetch_pc_q <= fetch_pc_q + 32'd4;
              state_q    <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              kill_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns ~addr, grant/response gating controlled per step.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        misalign_err;

  logic        gnt_en, rv_en;
  logic        pend = 1'b0;
  logic [31:0] maddr = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .misalign_err(misalign_err)
  );

  // Single-outstanding memory: response held pending until rv_en lets it through.
  assign imem_gnt    = gnt_en & imem_req;
  assign imem_rvalid = pend & rv_en;
  assign imem_rdata  = ~maddr;

  always @(posedge clk) begin
    if (imem_req && imem_gnt) begin
      pend  <= 1'b1;
      maddr <= imem_addr;
    end else if (imem_rvalid) begin
      pend  <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    instr_ready = 1'b1; gnt_en = 1'b1; rv_en = 1'b1;
    tick(); tick();
    chk("rst_req",      {31'b0, imem_req},     32'h0);
    chk("rst_valid",    {31'b0, instr_valid},  32'h0);
    chk("rst_misalign", {31'b0, misalign_err}, 32'h0);
    chk("rst_instr",    instr,    32'h0);
    chk("rst_pc",       pc,       32'h0);
    chk("rst_pc4",      pc_plus4, 32'h0);

    // Streaming at one instruction per two cycles
    rst = 1'b1; settle();
    chk("first_req",  {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0000_0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stream_gap", {31'b0, instr_valid}, 32'h0);
      tick();
      chk("stream_valid", {31'b0, instr_valid}, 32'h1);
      chk("stream_pc",    pc,       32'h100 + 32'(4 * i));
      chk("stream_instr", instr,    ~(32'h100 + 32'(4 * i)));
      chk("stream_pc4",   pc_plus4, 32'h104 + 32'(4 * i));
    end

    // Backpressure: buffer fills to two, request stops
    instr_ready = 1'b0;
    tick(); tick();
    for (int k = 0; k < 8; k++) begin
      chk("bp_req",   {31'b0, imem_req},    32'h0);
      chk("bp_valid", {31'b0, instr_valid}, 32'h1);
      tick();
    end
    chk("bp_req_end", {31'b0, imem_req}, 32'h0);
    chk("bp_head",    pc, 32'h0000_0108);
    instr_ready = 1'b1;
    tick();
    chk("drain_pc",    pc,    32'h0000_010C);
    chk("drain_instr", instr, ~32'h0000_010C);
    rv_en = 1'b0;
    tick();
    chk("drain_empty", {31'b0, instr_valid}, 32'h0);

    // Redirect while a response is pending
    redirect = 1'b1; redirect_pc = 32'h0000_0200; settle();
    chk("rdw_req", {31'b0, imem_req}, 32'h0);
    tick();
    redirect = 1'b0; rv_en = 1'b1; settle();
    chk("rdw_valid", {31'b0, instr_valid}, 32'h0);
    chk("rdw_noreq", {31'b0, imem_req},    32'h0);
    tick();
    chk("kill_drop", {31'b0, instr_valid}, 32'h0);
    chk("rdw_req2",  {31'b0, imem_req},    32'h1);
    chk("rdw_addr",  imem_addr, 32'h0000_0200);
    tick(); tick();
    chk("rdw_pc",    pc,    32'h0000_0200);
    chk("rdw_instr", instr, ~32'h0000_0200);

    // Full buffer, pop and redirect in the same cycle
    instr_ready = 1'b0;
    tick(); tick();
    chk("full_head", pc, 32'h0000_0200);
    chk("full_req",  {31'b0, imem_req}, 32'h0);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0040; settle();
    chk("full_rd_req", {31'b0, imem_req}, 32'h0);
    tick();
    redirect = 1'b0; settle();
    chk("flush_valid", {31'b0, instr_valid}, 32'h0);
    chk("flush_req",   {31'b0, imem_req},    32'h1);
    chk("flush_addr",  imem_addr, 32'h0000_0040);
    tick(); tick();
    chk("flush_pc", pc, 32'h0000_0040);

    // Redirect coincident with rvalid, misaligned target near the top of memory
    instr_ready = 1'b0;
    tick();
    chk("co_head", pc, 32'h0000_0040);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0; settle();
    chk("co_valid",  {31'b0, instr_valid},  32'h0);
    chk("mis_pulse", {31'b0, misalign_err}, 32'h1);
    chk("mis_req",   {31'b0, imem_req},     32'h1);
    chk("mis_addr",  imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("mis_clear", {31'b0, misalign_err}, 32'h0);
    tick();
    chk("wrap_pc",    pc,       32'hFFFF_FFFC);
    chk("wrap_instr", instr,    32'h0000_0003);
    chk("wrap_pc4",   pc_plus4, 32'h0000_0000);
    chk("wrap_addr",  imem_addr, 32'h0000_0000);
    tick();
    chk("wrap_gap", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("wrap0_pc",  pc,       32'h0000_0000);
    chk("wrap0_pc4", pc_plus4, 32'h0000_0004);

    // Reset while a response is outstanding
    tick();
    rst = 1'b0; rv_en = 1'b0;
    tick();
    chk("mrst_req",   {31'b0, imem_req},    32'h0);
    chk("mrst_valid", {31'b0, instr_valid}, 32'h0);
    rst = 1'b1; gnt_en = 1'b0; rv_en = 1'b1; settle();
    chk("mrst_req2", {31'b0, imem_req}, 32'h1);
    chk("mrst_addr", imem_addr, 32'h0000_0100);
    tick();
    chk("late_rvalid", {31'b0, instr_valid}, 32'h0);
    chk("hold_req",    {31'b0, imem_req},    32'h1);
    chk("hold_addr",   imem_addr, 32'h0000_0100);
    gnt_en = 1'b1;
    tick(); tick();
    chk("mrst_pc",    pc,    32'h0000_0100);
    chk("mrst_instr", instr, ~32'h0000_0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
